// File: rtl/dff_arb_pkg.sv
// Shared types for the dff_bank_arbiter: FSM encodings and the round-robin search helper.
package dff_arb_pkg;

   localparam int unsigned ST_W     = 2;
   localparam int unsigned RR_MAX_N = 8;
   localparam int unsigned RR_IDX_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_LOCK  = 2'b10
   } state_e;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of req_mask found by scanning ptr+1, ptr+2, ... modulo n.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req_mask,
                                        input logic [RR_IDX_W-1:0] ptr,
                                        input int unsigned         n);
      rr_pick_t            res;
      logic [RR_IDX_W-1:0] cand;
      res = '0;
      for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
         cand = RR_IDX_W'((32'(ptr) + k) % n);
         if (!res.found && (k <= n) && req_mask[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dff_reg.sv
// W-bit D register with load enable; qn is kept as its own flop so both outputs are registered.
module dff_reg
#(
   parameter int unsigned W = 8
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] qn
);

   logic [W-1:0] q_q, q_d;
   logic [W-1:0] qn_q, qn_d;

   always_comb begin
      q_d  = q_q;
      qn_d = qn_q;
      if (en) begin
         q_d  = d;
         qn_d = ~d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q  <= '0;
         qn_q <= '1;
      end else begin
         q_q  <= q_d;
         qn_q <= qn_d;
      end
   end

   assign q  = q_q;
   assign qn = qn_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N writers.
// Define ARB_LOCK_EN to add the lock port and the bounded burst-lock state.
module dff_bank_arbiter
   import dff_arb_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned W        = 8,
   parameter int unsigned MAX_LOCK = 8
)
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] wdata,
`ifdef ARB_LOCK_EN
   input  logic [N-1:0]   lock,
`endif
   output logic [N-1:0]   gnt,
   output logic [W-1:0]   q,
   output logic [W-1:0]   qn,
   output logic           busy
);

   localparam int unsigned PTR_W = $clog2(N);

   if (N < 2 || N > RR_MAX_N || MAX_LOCK < 1) begin : g_bad_param
      $error("dff_bank_arbiter: N must be 2..8 and MAX_LOCK at least 1");
   end

   state_e           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             busy_q, busy_d;
   logic [N-1:0]     elig;
   rr_pick_t         pick;
   logic             hold_lock;
   logic [W-1:0]     wsel;

   // The current grantee sits out one arbitration round unless it holds a lock.
   assign elig = req & ~gnt_q;
   assign pick = rr_pick(RR_MAX_N'(elig), RR_IDX_W'(ptr_q), N);

`ifdef ARB_LOCK_EN
   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

   // lock_cnt counts consecutive granted cycles of the current grantee.
   assign hold_lock = (state_q != ST_IDLE) && (|(gnt_q & lock & req)) &&
                      (lock_cnt_q < CNT_W'(MAX_LOCK));

   always_comb begin
      lock_cnt_d = '0;
      if (hold_lock) begin
         lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end else if (pick.found) begin
         lock_cnt_d = CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt_q <= '0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
      end
   end
`else
   assign hold_lock = 1'b0;
`endif

   // Next-state, grant and pointer update.
   always_comb begin
      state_d = state_q;
      gnt_d   = '0;
      ptr_d   = ptr_q;
      if (hold_lock) begin
         state_d = ST_LOCK;
         gnt_d   = gnt_q;
      end else if (pick.found) begin
         state_d = ST_GRANT;
         gnt_d   = N'(1) << pick.idx;
         ptr_d   = PTR_W'(pick.idx);
      end else begin
         state_d = ST_IDLE;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ptr_q   <= PTR_W'(N - 1);
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   // Data of the writer granted this cycle; loaded at the next edge.
   always_comb begin
      wsel = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt_q[i]) begin
            wsel = wdata[i*W +: W];
         end
      end
   end

   dff_reg #(.W(W)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (|gnt_q),
      .d     (wsel),
      .q     (q),
      .qn    (qn)
   );

   assign gnt  = gnt_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter; the lock scenario runs when ARB_LOCK_EN is defined.
module tb_dff_bank_arbiter;

   localparam int unsigned N        = 4;
   localparam int unsigned W        = 8;
   localparam int unsigned MAX_LOCK = 8;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req;
   logic [N*W-1:0] wdata;
`ifdef ARB_LOCK_EN
   logic [N-1:0]   lock;
`endif
   logic [N-1:0]   gnt;
   logic [W-1:0]   q;
   logic [W-1:0]   qn;
   logic           busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [N-1:0] exp_gnt_q[$];
   logic [W-1:0] exp_q_q[$];
   logic         wr_pending = 1'b0;
   logic [N-1:0] mon_g;
   logic [W-1:0] mon_e;
   logic [W-1:0] mon_ne;

   always #5 clk = ~clk;

   dff_bank_arbiter #(.N(N), .W(W), .MAX_LOCK(MAX_LOCK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .wdata (wdata),
`ifdef ARB_LOCK_EN
      .lock  (lock),
`endif
      .gnt   (gnt),
      .q     (q),
      .qn    (qn),
      .busy  (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [N-1:0] g, input logic [W-1:0] d);
      exp_gnt_q.push_back(g);
      exp_q_q.push_back(d);
   endtask

   task automatic set_w(input int i, input logic [W-1:0] v);
      wdata[i*W +: W] = v;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
`ifdef ARB_LOCK_EN
      lock  = '0;
`endif
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Monitor: a grant pops the expected grantee; the cycle after a grant pops the written value.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_pending = 1'b0;
      end else begin
         if (wr_pending) begin
            if (exp_q_q.size() == 0) begin
               n_checks++;
               $display("FAIL q_unexpected: got %0h expected no write at %0t", q, $time);
            end else begin
               mon_e  = exp_q_q.pop_front();
               mon_ne = ~mon_e;
               check("sb_q", 32'(q), 32'(mon_e));
               check("sb_qn", 32'(qn), 32'(mon_ne));
            end
         end
         wr_pending = |gnt;
         if (|gnt) begin
            if (exp_gnt_q.size() == 0) begin
               n_checks++;
               $display("FAIL gnt_unexpected: got %0h expected no grant at %0t", gnt, $time);
            end else begin
               mon_g = exp_gnt_q.pop_front();
               check("sb_gnt", 32'(gnt), 32'(mon_g));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      req   = '1;
      wdata = '0;
`ifdef ARB_LOCK_EN
      lock  = '0;
`endif
      // Reset held with every requester active
      repeat (3) tick();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_q", 32'(q), 32'h00);
      check("rst_qn", 32'(qn), 32'hFF);
      check("rst_busy", 32'(busy), 32'h0);
      req   = '0;
      rst_n = 1'b1;
      tick();

      // Single writer
      set_w(2, 8'hA5);
      req = 4'b0100;
      push(4'b0100, 8'hA5);
      tick();
      check("single_busy", 32'(busy), 32'h1);
      req = '0;
      tick();
      check("single_gnt_drop", 32'(gnt), 32'h0);
      check("single_idle", 32'(busy), 32'h0);
      set_w(2, 8'h3C);
      repeat (2) tick();
      check("hold_q", 32'(q), 32'hA5);

      // Round-robin with all requesters held
      do_reset();
      set_w(0, 8'h11);
      set_w(1, 8'h22);
      set_w(2, 8'h33);
      set_w(3, 8'h44);
      req = 4'b1111;
      push(4'b0001, 8'h11);
      push(4'b0010, 8'h22);
      push(4'b0100, 8'h33);
      push(4'b1000, 8'h44);
      push(4'b0001, 8'h11);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rr_no_bubble", 32'(busy), 32'h1);
      end
      req = '0;
      tick();
      check("rr_idle", 32'(gnt), 32'h0);
      check("rr_last_q", 32'(q), 32'h11);

      // Async reset while requester 1 is granted
      set_w(1, 8'h77);
      req = 4'b0010;
      tick();
      check("ar_gnt", 32'(gnt), 32'h2);
      #1 rst_n = 1'b0;
      #1;
      check("ar_gnt_drop", 32'(gnt), 32'h0);
      check("ar_q", 32'(q), 32'h00);
      check("ar_qn", 32'(qn), 32'hFF);
      check("ar_busy", 32'(busy), 32'h0);
      req = '0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check("ar_no_write", 32'(q), 32'h00);

      // Fairness: requester 0 held, requester 2 pulsed once
      set_w(0, 8'h5A);
      set_w(2, 8'hC3);
      req = 4'b0001;
      push(4'b0001, 8'h5A);
      tick();
      req = 4'b0101;
      push(4'b0100, 8'hC3);
      tick();
      req = 4'b0001;
      push(4'b0001, 8'h5A);
      tick();
      tick();
      check("fair_no_repeat", 32'(gnt), 32'h0);
      push(4'b0001, 8'h5A);
      tick();
      check("fair_regrant", 32'(gnt), 32'h1);
      req = '0;
      tick();
      check("fair_idle", 32'(gnt), 32'h0);

`ifdef ARB_LOCK_EN
      // Locked burst capped at MAX_LOCK grants
      do_reset();
      set_w(1, 8'h21);
      set_w(3, 8'h43);
      req  = 4'b1010;
      lock = 4'b0010;
      for (int i = 0; i < 8; i++) push(4'b0010, 8'h21);
      push(4'b1000, 8'h43);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("lock_hold", 32'(gnt), 32'h2);
      end
      tick();
      check("lock_exit", 32'(gnt), 32'h8);
      req  = '0;
      lock = '0;
      tick();
      check("lock_idle", 32'(gnt), 32'h0);
`endif

      repeat (2) tick();
      check("sb_gnt_drained", 32'(exp_gnt_q.size()), 32'h0);
      check("sb_q_drained", 32'(exp_q_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
